serial_adder: RTL
=================

Name: serial_adder

Overview:
- Bit-serial, LSB-first multi-bit adder built around a single full-adder cell and a carry flip-flop.
- It is the inverse-direction companion of the team's full subtractor: addition instead of subtraction.
- With b inverted and cin=1 it performs a - b, so one block serves both directions.
- Sits in the arithmetic datapath and trades WIDTH cycles of latency for one-bit hardware; uses a start/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2)

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while in RUN or DONE
- done  output  1  one-cycle pulse: result valid
- sum  output  WIDTH  result; held until next accepted start
- cout  output  1  carry out of the MSB
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst_n=0, asynchronous, any state): state=IDLE; busy=0, done=0, sum=0, cout=0, overflow=0; shift registers, carry FF and bit counter cleared.
- Reset mid-operation aborts the addition; no done is produced. Operation resumes on the first clk edge after rst_n rises.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: load a_sr<=a, b_sr<=b, carry<=cin, cnt<=0, go to RUN; busy=1 from this edge.
  - start=0: remain in IDLE.
- RUN, each edge:
  - s = a_sr[0]^b_sr[0]^carry.
  - carry <= majority(a_sr[0], b_sr[0], carry).
  - sum_sr <= {s, sum_sr[WIDTH-1:1]}.
  - a_sr and b_sr shift right by one; cnt <= cnt+1.
  - Before the MSB step (cnt==WIDTH-1), latch c_msb_in <= carry.
  - On the edge where cnt==WIDTH-1: go to DONE.
- DONE, for exactly one cycle:
  - done=1; sum=sum_sr; cout=carry; overflow=c_msb_in^carry.
  - Next edge: IDLE, busy=0.
- Outputs sum/cout/overflow update only on entry to DONE and hold through IDLE until the next DONE.
- Latency: start sampled at edge E0, the WIDTH RUN steps occur at E1..EWIDTH, and done is high for the cycle following EWIDTH. The next start can be accepted at edge EWIDTH+2.
- start asserted while in RUN or DONE is ignored (not queued). a/b/cin may change freely after capture.
- Wrap-around: the result is modulo 2^WIDTH; cout carries bit WIDTH.
- Subtraction usage: a + ~b + cin=1 gives a-b; cout=1 means no borrow, cout=0 means borrow.
- Counter width: clog2(WIDTH)+1 bits; no other arithmetic beyond the 1-bit full-adder cell.

Test Plan:
- a=0x06, b=0x05, cin=0, start pulse -> done for 1 cycle exactly 9 cycles after start edge; sum=0x0B, cout=0, overflow=0, busy high 9 cycles.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0.
- a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, overflow=1. Then a=0x80, b=0x80 -> sum=0x00, cout=1, overflow=1.
- Subtract: a=0x01, b=~0x09=0xF6, cin=1 -> sum=0xF8, cout=0 (borrow). a=0x0D, b=~0x07=0xF8, cin=1 -> sum=0x06, cout=1.
- start held high continuously with a changing every cycle -> only the operand captured at the IDLE edge is summed; back-to-back results are spaced 10 cycles apart; outputs are stable between done pulses.
- rst_n pulled low 4 cycles into RUN -> all outputs 0 immediately (before the next clk edge) and no done. After release, a fresh start 0x0F+0x01 -> sum=0x10.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell plus a carry flip-flop,
// WIDTH cycles per addition with a start/done handshake.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Low WIDTH-1 result bits; the MSB goes straight to sum on the last step.
    logic [WIDTH-2:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             s_c;
    logic             carry_nxt_c;

    // Full-adder cell on the current LSBs.
    always_comb begin
        s_c         = a_sr[0] ^ b_sr[0] ^ carry;
        carry_nxt_c = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            sum_sr   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= (WIDTH-1)'({s_c, sum_sr} >> 1);
                    carry  <= carry_nxt_c;
                    cnt    <= cnt + CW'(1);
                    // MSB step: carry here is the carry into the MSB.
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum      <= {s_c, sum_sr};
                        cout     <= carry_nxt_c;
                        overflow <= carry ^ carry_nxt_c;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
